// File: rtl/input_debouncer.sv
// Multi-channel synchroniser, debouncer and edge detector for board keys and switches.
// Define DEBOUNCE_LONG_PRESS_EN to add a per-channel long-press pulse.
module input_debouncer #(
   parameter int unsigned        NUM_CH        = 4,
   parameter int unsigned        SYNC_STAGES   = 2,
   parameter int unsigned        STABLE_CYCLES = 1000000,
   parameter logic [NUM_CH-1:0]  ACTIVE_LOW    = {NUM_CH{1'b1}},
   parameter int unsigned        LONG_CYCLES   = 50000000
) (
   input  logic              CLOCK_50,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] raw_in,
   output logic [NUM_CH-1:0] level,
   output logic [NUM_CH-1:0] rise,
   output logic [NUM_CH-1:0] fall,
   output logic [NUM_CH-1:0] long_press
);

   localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || STABLE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_bad_param
      $error("input_debouncer: illegal parameter value");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      logic                   toggle;
      logic [CNT_W-1:0]       cnt_q;
      logic                   level_q;
      logic                   rise_q;
      logic                   fall_q;

      // Synchroniser resets to the idle pad value so release of reset never looks like a press.
      always_ff @(posedge CLOCK_50 or negedge rst_n) begin
         // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
         if (!rst_n) sync_q <= {SYNC_STAGES{ACTIVE_LOW[i]}};
         else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in[i]};
      end

      assign s      = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW[i];
      assign toggle = (s != level_q) && (cnt_q == CNT_MAX);

      always_ff @(posedge CLOCK_50 or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            rise_q <= toggle & ~level_q;
            fall_q <= toggle &  level_q;
            if (toggle) level_q <= ~level_q;
            // Any sample matching the current level restarts the count; the count never wraps.
            if (s == level_q || toggle) cnt_q <= '0;
            else                        cnt_q <= cnt_q + CNT_W'(1);
         end
      end

      assign level[i] = level_q;
      assign rise[i]  = rise_q;
      assign fall[i]  = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
      localparam int unsigned       HOLD_W   = $clog2(LONG_CYCLES + 1);
      localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
      localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

      logic [HOLD_W-1:0] hold_q;
      logic              long_q;

      // Saturating at HOLD_MAX gives one pulse per press; only a release clears it.
      always_ff @(posedge CLOCK_50 or negedge rst_n) begin
         if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
         end else if (!level_q) begin
            hold_q <= '0;
            long_q <= 1'b0;
         end else begin
            if (hold_q != HOLD_MAX) hold_q <= hold_q + HOLD_W'(1);
            long_q <= (hold_q == HOLD_PRE);
         end
      end

      assign long_press[i] = long_q;
`endif
   end

`ifndef DEBOUNCE_LONG_PRESS_EN
   assign long_press = '0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: table-driven press/release vectors plus
// hand-written bounce, multi-channel, mid-count reset and long-press sequences.
module tb_input_debouncer;

   logic       CLOCK_50 = 1'b0;
   logic       rst_n    = 1'b0;
   logic [3:0] raw_in   = 4'b1111;
   logic [3:0] level, rise, fall, long_press;

   int checks = 0;
   int errors = 0;

   int rise_cnt [4] = '{default: 0};
   int fall_cnt [4] = '{default: 0};
   int long_cnt [4] = '{default: 0};
   int both_cnt     = 0;

   typedef struct {
      string      name;
      logic [3:0] raw;
      int         cycles;
      logic [3:0] exp_level;
      logic [3:0] exp_rise;
      logic [3:0] exp_fall;
   } vec_t;

   vec_t vecs [6];

   input_debouncer #(
      .NUM_CH(4), .SYNC_STAGES(2), .STABLE_CYCLES(8), .ACTIVE_LOW(4'b1111), .LONG_CYCLES(20)
   ) dut (
      .CLOCK_50(CLOCK_50), .rst_n(rst_n), .raw_in(raw_in),
      .level(level), .rise(rise), .fall(fall), .long_press(long_press)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Pulse bookkeeping sampled on the inactive edge.
   always @(negedge CLOCK_50) begin
      for (int i = 0; i < 4; i++) begin
         if (rise[i])       rise_cnt[i]++;
         if (fall[i])       fall_cnt[i]++;
         if (long_press[i]) long_cnt[i]++;
         if (rise[i] && fall[i]) both_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   function automatic int pulses(input int ch);
      return rise_cnt[ch] + fall_cnt[ch] + long_cnt[ch];
   endfunction

   task automatic long_press_run(input string tag);
      int n_long, pos, other;
      raw_in[2] = 1'b0;
      for (int k = 0; k < 20 && !rise[2]; k++) tick();
      check({tag, "_rise_seen"}, rise[2], 1'b1);
      n_long = 0; pos = -1; other = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (long_press[2]) begin
            n_long++;
            pos = k;
         end
         if ((long_press & 4'b1011) != 4'b0000) other++;
      end
      check({tag, "_other_ch_long"}, other, 0);
`ifdef DEBOUNCE_LONG_PRESS_EN
      check({tag, "_long_count"}, n_long, 1);
      check({tag, "_long_pos"}, pos, 20);
`else
      check({tag, "_long_count"}, n_long, 0);
`endif
      raw_in[2] = 1'b1;
      repeat (10) tick();
      check({tag, "_release_fall"}, fall[2], 1'b1);
      repeat (2) tick();
      check({tag, "_release_level"}, level, 4'b0000);
   endtask

   initial begin
      int snap, snap_long;

      vecs[0] = '{"press_t9",   4'b1110, 9, 4'b0000, 4'b0000, 4'b0000};
      vecs[1] = '{"press_t10",  4'b1110, 1, 4'b0001, 4'b0001, 4'b0000};
      vecs[2] = '{"press_t11",  4'b1110, 1, 4'b0001, 4'b0000, 4'b0000};
      vecs[3] = '{"release_u9", 4'b1111, 9, 4'b0001, 4'b0000, 4'b0000};
      vecs[4] = '{"release_u10",4'b1111, 1, 4'b0000, 4'b0000, 4'b0001};
      vecs[5] = '{"release_u11",4'b1111, 1, 4'b0000, 4'b0000, 4'b0000};

      // 1. Reset with idle pads, then 30 idle cycles
      #1;
      check("rst_level", level, 4'b0000);
      check("rst_pulses", {rise, fall, long_press}, 12'h000);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (30) tick();
      check("idle_level", level, 4'b0000);
      check("idle_pulse_total", pulses(0) + pulses(1) + pulses(2) + pulses(3), 0);

      // 2. Clean press and release on channel 0
      foreach (vecs[v]) begin
         raw_in = vecs[v].raw;
         repeat (vecs[v].cycles) tick();
         check({vecs[v].name, "_level"}, level, vecs[v].exp_level);
         check({vecs[v].name, "_rise"},  rise,  vecs[v].exp_rise);
         check({vecs[v].name, "_fall"},  fall,  vecs[v].exp_fall);
      end

      // 3. Bounce rejection on channel 1: low 5, high 1, low 7, high
      snap = pulses(1);
      raw_in[1] = 1'b0; repeat (5) tick();
      raw_in[1] = 1'b1; tick();
      raw_in[1] = 1'b0; repeat (7) tick();
      raw_in[1] = 1'b1; repeat (15) tick();
      check("bounce_level", level[1], 1'b0);
      check("bounce_pulses", pulses(1) - snap, 0);

      // 4. Channels 3 and 2 pressed together while channel 0 bounces
      snap = pulses(0);
      for (int k = 0; k < 10; k++) begin
         raw_in[3:2] = 2'b00;
         raw_in[0]   = (k == 3 || k >= 7);
         tick();
      end
      check("multi_level", level, 4'b1100);
      check("multi_rise", rise, 4'b1100);
      tick();
      check("multi_rise_width", rise, 4'b0000);
      raw_in = 4'b1111;
      repeat (10) tick();
      check("multi_fall", fall, 4'b1100);
      repeat (4) tick();
      check("multi_ch0_pulses", pulses(0) - snap, 0);
      check("multi_settled", level, 4'b0000);

      // 5. Reset pulse mid-count (count = 5) on channel 0
      snap = rise_cnt[0];
      raw_in[0] = 1'b0;
      repeat (7) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_level_in_reset", level[0], 1'b0);
      tick();
      rst_n = 1'b1;
      repeat (9) tick();
      check("midrst_level_early", level[0], 1'b0);
      check("midrst_no_rise_early", rise_cnt[0] - snap, 0);
      tick();
      check("midrst_level_full", level[0], 1'b1);
      check("midrst_rise_full", rise[0], 1'b1);
      raw_in[0] = 1'b1;
      repeat (12) tick();
      check("midrst_settled", level, 4'b0000);

      // 6. Long press on channel 2, twice to confirm re-arming after release
      snap_long = long_cnt[0] + long_cnt[1] + long_cnt[3];
      long_press_run("long1");
      long_press_run("long2");
      check("long_other_total", long_cnt[0] + long_cnt[1] + long_cnt[3] - snap_long, 0);

      check("rise_fall_overlap", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Parametrised, multi-channel debouncer and edge detector for board pushbuttons and switches (KEY[3:0], SW[9:0]) on the DE1-SoC 50 MHz domain.
- Replaces the single-flop sampling of one key with a per-channel synchroniser and a stability counter.
- Per-channel polarity normalisation.
- Outputs a clean level plus one-cycle rise and fall pulses, for use as user reset requests, mode toggles and step strobes.

Parameters:
- NUM_CH, 4, number of independent input channels.
- SYNC_STAGES, 2, flops in each channel's synchroniser chain; legal range 2..4.
- STABLE_CYCLES, 1000000, consecutive clock cycles a synchronised input must differ from the current level before the level changes; 20 ms at 50 MHz; minimum 2.
- ACTIVE_LOW, {NUM_CH{1'b1}}, per-channel mask; bit i = 1 means raw_in[i] is asserted when low.
- LONG_CYCLES, 50000000, hold time for the long-press pulse (1 s); used only with the optional feature.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- raw_in  in  NUM_CH  raw pad inputs, asynchronous to CLOCK_50.
- level  out  NUM_CH  debounced, polarity-normalised level; 1 = asserted.
- rise  out  NUM_CH  one-cycle pulse when level goes 0->1.
- fall  out  NUM_CH  one-cycle pulse when level goes 1->0.
- long_press  out  NUM_CH  one-cycle pulse after level has been held at 1 for LONG_CYCLES.

Behaviour:
- Reset: one clock, CLOCK_50. Reset is asynchronous and active-low on rst_n.
  - While rst_n = 0, every synchroniser flop of channel i holds ACTIVE_LOW[i], i.e. the deasserted pad value.
  - Under reset: level, rise, fall, long_press = 0; all counters = 0.
  - Release of rst_n has no effect until the next CLOCK_50 edge. No pulses are generated by the release itself.
- Synchroniser: raw_in[i] passes through SYNC_STAGES flops. The last stage is XORed with ACTIVE_LOW[i] to give s[i].
- Stability counter, per channel:
  - Width is clog2(STABLE_CYCLES).
  - If s[i] == level[i], the counter clears to 0.
  - If s[i] != level[i] and the counter < STABLE_CYCLES-1, the counter increments.
  - If s[i] != level[i] and the counter == STABLE_CYCLES-1: at the next edge level[i] toggles and the counter clears.
- Latency:
  - A clean raw edge reaches level after exactly SYNC_STAGES + STABLE_CYCLES clock edges.
  - A glitch shorter than STABLE_CYCLES cycles at s[i] produces no level change. Any single-cycle return to the current level restarts the count from 0.
- Edge pulses: rise[i] / fall[i] are registered and asserted in the same cycle level[i] first shows its new value. Width is exactly 1 cycle. rise and fall are never high together on one channel.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- Reset mid-count: the count is discarded; the channel restarts from the deasserted state.
- Counters never wrap: the maximum value reached is STABLE_CYCLES-1.

Optional Feature:
- Macro: DEBOUNCE_LONG_PRESS_EN.
- When defined, each channel has a hold counter of width clog2(LONG_CYCLES+1):
  - The counter clears when level[i] = 0 and increments while level[i] = 1.
  - It saturates at LONG_CYCLES.
  - long_press[i] pulses for one cycle on the cycle the counter reaches LONG_CYCLES.
  - Exactly one pulse per press; re-arms only after fall[i].
- When not defined: the long_press port still exists, is tied to 0, and no hold counters are instantiated.

Test Plan:
All scenarios use NUM_CH=4, SYNC_STAGES=2, STABLE_CYCLES=8, ACTIVE_LOW=4'b1111, LONG_CYCLES=20, macro defined unless stated.
1. Reset:
   - Stimulus: rst_n=0 with raw_in=4'b1111, release, hold raw_in for 30 cycles.
   - Required: level=0; rise, fall and long_press never pulse.
2. Clean press:
   - Stimulus: raw_in[0] 1->0 at cycle T.
   - Required: level[0]=1 and rise[0]=1 first seen at edge T+10, rise[0] low again at T+11. Release 1 at cycle U -> fall[0] at U+10.
3. Bounce rejection:
   - Stimulus: raw_in[1] toggled low for 5 cycles, high for 1, low for 7, then high.
   - Required: level[1] stays 0; no pulses.
4. Simultaneous channels and independence:
   - Stimulus: raw_in[3:2] driven low in the same cycle; raw_in[0] bounces.
   - Required: rise[3] and rise[2] assert in the same cycle; channel 0 is unaffected.
5. Reset mid-count:
   - Stimulus: raw_in[0] low; rst_n pulsed low at count 5 for 1 cycle.
   - Required: level[0] stays 0. After release, a full 2+8 cycles are needed before rise[0].
6. Long press:
   - Stimulus: hold raw_in[2] low for 40 cycles after level[2]=1.
   - Required: exactly one long_press[2] pulse, 20 cycles after rise[2].
   - Without the macro, the same stimulus leaves long_press = 0.
